// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module      : serial_adder (with local full_adder stage)
// Description : Bit-serial WIDTH-bit adder controller. Accepts two operands
//               plus carry-in over a valid/ready handshake, feeds one bit pair
//               per cycle (LSB first) through a full_adder, registers the
//               ripple carry between cycles and returns {c_out, sum_out} over
//               a valid/ready handshake.
//               Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input
//               that selects a - b (c_out = 1 means no borrow).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);

    // Bit counter only has to reach WIDTH-1.
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_run  = 2'd1,
        c_st_done = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Only the upper WIDTH-1 sum bits need storing: the newest bit comes
    // straight from the full adder on the final RUN cycle.
    logic [WIDTH-2:0]   r_sum_hi;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_sum_cat;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

    // Operand-load selection: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b_in : b_in;
    assign w_c_load = sub ? 1'b1  : c_in;
`else
    assign w_b_load = b_in;
    assign w_c_load = c_in;
`endif

    // Accept only from IDLE and never while reset is held.
    assign in_ready = (r_state == c_st_idle) && !rst;

    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_cout)
    );

    // Sum bits collected so far with the current bit inserted at the top;
    // after WIDTH shifts this is the complete sum, LSB at bit 0.
    assign w_sum_cat = {w_fa_sum, r_sum_hi};

    // Control FSM, serial datapath and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_hi  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            c_out     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end

                c_st_run: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_hi <= w_sum_cat[WIDTH-1:1];
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_last) begin
                        sum_out   <= w_sum_cat;
                        c_out     <= w_fa_cout;
                        out_valid <= 1'b1;
                        r_state   <= c_st_done;
                    end
                end

                c_st_done: begin
                    // Result held stable until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
